// File: rtl/alu_reg_sseg.sv
// Registered 4-function ALU with operand/opcode/result registers and a 4-digit multiplexed hex display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits above the most significant nonzero nibble.
module alu_reg_sseg #(
    parameter int N           = 16,
    parameter int REFRESH_DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_A,
    input  logic         load_B,
    input  logic         load_Op,
    input  logic         updateRes,
    input  logic [N-1:0] data_in,
    output logic [6:0]   Segments,
    output logic [3:0]   Anodes,
    output logic [3:0]   LEDs
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [N-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       anodes_q, anodes_d;
    logic [6:0]       seg_q, seg_d;

    logic             is_sub;
    logic [N-1:0]     b_eff;
    logic [N:0]       sum;
    logic [N-1:0]     alu_res;
    logic             alu_c, alu_v;
    logic [15:0]      disp;
    logic [15:0]      disp_hi;

    function automatic logic [6:0] hex_glyph(input logic [3:0] h);
        case (h)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            default: hex_glyph = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        a_d  = load_A  ? data_in      : a_q;
        b_d  = load_B  ? data_in      : b_q;
        op_d = load_Op ? data_in[1:0] : op_q;

        // SUB is A + ~B + 1 so carry and overflow fall out of the same adder as ADD
        is_sub  = (op_q == 2'b00);
        b_eff   = is_sub ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a_q[N-1] == b_eff[N-1]) && (sum[N-1] != a_q[N-1]);
        case (op_q)
            2'b10: begin
                alu_res = a_q | b_q;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            2'b11: begin
                alu_res = a_q & b_q;
                alu_c   = 1'b0;
                alu_v   = 1'b0;
            end
            default: ;
        endcase

        res_d   = updateRes ? alu_res : res_q;
        flags_d = updateRes ? {alu_res[N-1], (alu_res == '0), alu_c, alu_v} : flags_q;

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        // Glyph is built from the next-cycle result and digit so a fresh Result shows immediately
        disp     = 16'(res_d);
        disp_hi  = disp >> {idx_d, 2'b00};
        anodes_d = ~(4'b0001 << idx_d);
        seg_d    = hex_glyph(disp_hi[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_d != 2'd0) && (disp_hi == 16'd0)) begin
            seg_d = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            anodes_q <= 4'b1110;
            seg_q    <= 7'b1000000;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            anodes_q <= anodes_d;
            seg_q    <= seg_d;
        end
    end

    assign Segments = seg_q;
    assign Anodes   = anodes_q;
    assign LEDs     = flags_q;

endmodule

// File: tb/tb_alu_reg_sseg.sv
// Randomized and directed bench for alu_reg_sseg against an arithmetic reference model.
module tb_alu_reg_sseg;

    localparam int N = 16;
    localparam longint LIM = 64'd1 << N;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_A = 1'b0, load_B = 1'b0, load_Op = 1'b0, updateRes = 1'b0;
    logic [N-1:0] data_in = '0;
    logic [6:0]   Segments;
    logic [3:0]   Anodes;
    logic [3:0]   LEDs;

    int total = 0;
    int bad   = 0;

    longint   m_a, m_b, m_op, m_res;
    logic [3:0] m_flags;
    int       m_idx;

    logic [6:0] glyphs [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    alu_reg_sseg #(.N(N), .REFRESH_DIV(1)) dut (
        .clk(clk), .reset(reset), .load_A(load_A), .load_B(load_B),
        .load_Op(load_Op), .updateRes(updateRes), .data_in(data_in),
        .Segments(Segments), .Anodes(Anodes), .LEDs(LEDs)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input longint val, input int idx);
        longint hi;
        hi = (val % 65536) >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx != 0 && hi == 0) return 7'b1111111;
`endif
        return glyphs[hi % 16];
    endfunction

    function automatic longint to_signed(input longint v);
        return (v >= LIM / 2) ? v - LIM : v;
    endfunction

    task automatic model_alu(output longint r, output logic [3:0] f);
        longint s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (m_op)
            0: begin
                r = (m_a - m_b + LIM) % LIM;
                c = (m_a >= m_b);
                s = to_signed(m_a) - to_signed(m_b);
                v = (s >= LIM / 2) || (s < -LIM / 2);
            end
            1: begin
                r = (m_a + m_b) % LIM;
                c = (m_a + m_b) >= LIM;
                s = to_signed(m_a) + to_signed(m_b);
                v = (s >= LIM / 2) || (s < -LIM / 2);
            end
            2: r = m_a | m_b;
            default: r = m_a & m_b;
        endcase
        f = {r >= LIM / 2, r == 0, c, v};
    endtask

    task automatic step(input bit rst, input bit la, input bit lb, input bit lop,
                        input bit upd, input logic [N-1:0] d);
        longint r;
        logic [3:0] f;
        reset = rst; load_A = la; load_B = lb; load_Op = lop; updateRes = upd; data_in = d;
        @(posedge clk);
        if (rst) begin
            m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 4'b0000; m_idx = 0;
        end else begin
            if (upd) begin
                model_alu(r, f);
                m_res   = r;
                m_flags = f;
            end
            if (la)  m_a  = longint'(d);
            if (lb)  m_b  = longint'(d);
            if (lop) m_op = longint'(d) % 4;
            m_idx = (m_idx + 1) % 4;
        end
        @(negedge clk);
    endtask

    task automatic load_all(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        step(0, 1, 0, 0, 0, a);
        step(0, 0, 1, 0, 0, b);
        step(0, 0, 0, 1, 0, {{(N-2){1'b0}}, op});
    endtask

    task automatic test_reset;
        logic [3:0] exp_an [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);
        total++;
        if (LEDs !== 4'b0000) begin bad++; $display("FAIL reset_leds got=%b want=0000", LEDs); end
        total++;
        if (Anodes !== 4'b1110) begin bad++; $display("FAIL reset_anodes got=%b want=1110", Anodes); end
        total++;
        if (Segments !== 7'b1000000) begin bad++; $display("FAIL reset_seg got=%b want=1000000", Segments); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, N'($urandom));
            total++;
            if (Anodes !== exp_an[i] || Segments !== exp_seg(0, (i + 1) % 4)) begin
                bad++;
                $display("FAIL reset_scan%0d got an=%b seg=%b want an=%b seg=%b",
                         i, Anodes, Segments, exp_an[i], exp_seg(0, (i + 1) % 4));
            end
        end
    endtask

    task automatic test_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [1:0] op, input longint exp_val, input logic [3:0] exp_leds);
        load_all(a, b, op);
        step(0, 0, 0, 0, 1, '0);
        total++;
        if (LEDs !== exp_leds) begin bad++; $display("FAIL %s_leds got=%b want=%b", name, LEDs, exp_leds); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0, 0, 0, 0, 0, N'($urandom));
            total++;
            if (Anodes !== ~(4'b0001 << m_idx) || Segments !== exp_seg(exp_val, m_idx)) begin
                bad++;
                $display("FAIL %s_digit%0d got an=%b seg=%b want an=%b seg=%b", name, m_idx,
                         Anodes, Segments, ~(4'b0001 << m_idx), exp_seg(exp_val, m_idx));
            end
        end
    endtask

    task automatic test_update_with_load;
        load_all(16'hF0F0, 16'h0F0F, 2'b11);
        step(0, 0, 0, 0, 1, '0);
        total++;
        if (LEDs !== 4'b0100 || Segments !== exp_seg(0, m_idx)) begin
            bad++; $display("FAIL and_zero got leds=%b seg=%b want leds=0100 seg=%b", LEDs, Segments, exp_seg(0, m_idx));
        end
        step(0, 1, 0, 0, 1, 16'hFFFF);
        total++;
        if (LEDs !== 4'b0100 || Segments !== exp_seg(0, m_idx)) begin
            bad++; $display("FAIL upd_old_a got leds=%b seg=%b want leds=0100 seg=%b", LEDs, Segments, exp_seg(0, m_idx));
        end
        step(0, 0, 0, 0, 1, '0);
        total++;
        if (LEDs !== 4'b0000) begin bad++; $display("FAIL upd_new_a_leds got=%b want=0000", LEDs); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(0, 0, 0, 0, 0, '0);
            total++;
            if (Segments !== exp_seg(64'h0F0F, m_idx)) begin
                bad++; $display("FAIL upd_new_a_digit%0d got=%b want=%b", m_idx, Segments, exp_seg(64'h0F0F, m_idx));
            end
        end
    endtask

    task automatic test_random;
        bit rst, la, lb, lop, upd;
        int lows;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            la  = $urandom_range(0, 3) == 0;
            lb  = $urandom_range(0, 3) == 0;
            lop = $urandom_range(0, 3) == 0;
            upd = $urandom_range(0, 2) == 0;
            step(rst, la, lb, lop, upd, N'($urandom));
            lows = 0;
            for (int k = 0; k < 4; k++) if (Anodes[k] === 1'b0) lows++;
            total++;
            if (lows != 1 || Anodes !== ~(4'b0001 << m_idx)) begin
                bad++; $display("FAIL rnd_anodes cyc=%0d got=%b want=%b", cyc, Anodes, ~(4'b0001 << m_idx));
            end
            total++;
            if (Segments !== exp_seg(m_res, m_idx)) begin
                bad++; $display("FAIL rnd_seg cyc=%0d res=%h got=%b want=%b", cyc, m_res, Segments, exp_seg(m_res, m_idx));
            end
            total++;
            if (LEDs !== m_flags) begin
                bad++; $display("FAIL rnd_leds cyc=%0d got=%b want=%b", cyc, LEDs, m_flags);
            end
        end
    endtask

    initial begin
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 4'b0000; m_idx = 0;
        @(negedge clk);
        test_reset();
        test_op("add",     16'h1234, 16'h1111, 2'b01, 64'h2345, 4'b0000);
        test_op("sub_neg", 16'h0005, 16'h0007, 2'b00, 64'hFFFE, 4'b1000);
        test_op("add_ovf", 16'h7FFF, 16'h0001, 2'b01, 64'h8000, 4'b1001);
        test_op("add_cz",  16'hFFFF, 16'h0001, 2'b01, 64'h0000, 4'b0110);
        test_op("sub_eq",  16'h1234, 16'h1234, 2'b00, 64'h0000, 4'b0110);
        test_op("sub_ovf", 16'h8000, 16'h0001, 2'b00, 64'h7FFF, 4'b0011);
        test_op("or",      16'h0A00, 16'h0050, 2'b10, 64'h0A50, 4'b0000);
        test_update_with_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
